// File: rtl/icmp_rx_arbiter.sv
// Round-robin message arbiter sharing one ICMP_read parser between two word sources.
// Define ICMP_CHECKSUM_CHECK_EN to build the ones'-complement checksum check on chk_err.
module icmp_rx_arbiter #(
    parameter int WORDS     = 5,
    parameter int STALL_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        out_src,
    output logic        msg_done,
    output logic        msg_abort,
    output logic        chk_err
);
    localparam int              CW        = $clog2(WORDS);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(WORDS - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [7:0]      STALL_LIM = 8'(STALL_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_src;
    logic          r_last_grant;
    logic [CW-1:0] r_word_cnt;
    logic [7:0]    r_stall_cnt;
    logic          r_out_valid;
    logic [31:0]   r_out_data;
    logic          r_out_first;
    logic          r_out_last;
    logic          r_msg_done;
    logic          r_msg_abort;

    logic          w_sel_valid;
    logic [31:0]   w_sel_data;
    logic          w_accept;
    logic          w_accept_last;
    logic          w_grant_valid;
    logic          w_grant;

    // Granted-source mux and round-robin pick for the next grant
    always_comb begin
        w_sel_valid   = r_src ? req1_valid : req0_valid;
        w_sel_data    = r_src ? req1_data  : req0_data;
        w_accept      = (r_state == S_XFER) && w_sel_valid;
        w_accept_last = w_accept && (r_word_cnt == LAST_IDX);
        w_grant_valid = (r_state == S_IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    assign req0_ready = (r_state == S_XFER) && !r_src;
    assign req1_ready = (r_state == S_XFER) &&  r_src;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign out_src    = r_src;
    assign msg_done   = r_msg_done;
    assign msg_abort  = r_msg_abort;

    // Message FSM with registered framing outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_word_cnt   <= CNT_ZERO;
            r_stall_cnt  <= 8'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'h0000_0000;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_msg_done   <= 1'b0;
            r_msg_abort  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_msg_done  <= 1'b0;
            r_msg_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_src        <= w_grant;
                        r_last_grant <= w_grant;
                        r_word_cnt   <= CNT_ZERO;
                        r_stall_cnt  <= 8'd0;
                        r_state      <= S_XFER;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sel_data;
                        r_out_first <= (r_word_cnt == CNT_ZERO);
                        r_out_last  <= w_accept_last;
                        r_stall_cnt <= 8'd0;
                        if (w_accept_last) begin
                            r_msg_done <= 1'b1;
                            r_word_cnt <= CNT_ZERO;
                            r_state    <= S_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_ONE;
                        end
                    end else if ((r_stall_cnt + 8'd1) >= STALL_LIM) begin
                        // last_grant already names this source, so the other wins the next tie
                        r_stall_cnt <= STALL_LIM;
                        r_msg_abort <= 1'b1;
                        r_state     <= S_ABORT;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICMP_CHECKSUM_CHECK_EN
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    logic [15:0] r_csum;
    logic        r_chk_err;
    logic [15:0] w_csum_next;

    assign w_csum_next = ones_add(ones_add(r_csum, w_sel_data[31:16]), w_sel_data[15:0]);
    assign chk_err     = r_chk_err;

    // Checksum accumulator; verdict raised alongside msg_done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_csum    <= 16'h0000;
            r_chk_err <= 1'b0;
        end else begin
            r_chk_err <= 1'b0;
            if (w_grant_valid) begin
                r_csum <= 16'h0000;
            end else if (w_accept) begin
                r_csum    <= w_csum_next;
                r_chk_err <= w_accept_last && (w_csum_next != 16'hFFFF);
            end else begin
                r_csum <= r_csum;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_icmp_rx_arbiter.sv
// Self-checking bench for icmp_rx_arbiter: random words from two queue-backed sources
// scored against a message-level model of framing, stalls, aborts and checksums.
module tb_icmp_rx_arbiter;
    localparam int WORDS     = 5;
    localparam int STALL_MAX = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_data = 32'h0, req1_data = 32'h0;
    logic        req0_ready, req1_ready;
    logic        out_valid, out_first, out_last, out_src, msg_done, msg_abort, chk_err;
    logic [31:0] out_data;

    icmp_rx_arbiter #(.WORDS(WORDS), .STALL_MAX(STALL_MAX)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_src(out_src), .msg_done(msg_done),
        .msg_abort(msg_abort), .chk_err(chk_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Source model: whole messages queued per source, with an enable per source
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          en[2];
    int          pos[2];
    int          idle_run;
    int unsigned msg_sum;

    // Expected registered outputs for the cycle being sampled
    bit          e_valid, e_first, e_last, e_src, e_done, e_abort, e_chk;
    logic [31:0] e_data;

    int first_cyc[$];
    int first_src[$];
    int last_cyc[$];
    int abort_cyc[$];
    int done_cnt;
    int chk_cnt;

    function automatic logic [15:0] fold16(input int unsigned s);
        int unsigned t;
        t = s;
        while (t > 32'h0000_FFFF) t = (t & 32'h0000_FFFF) + (t >> 16);
        return 16'(t);
    endfunction

    task automatic clear_logs();
        first_cyc.delete(); first_src.delete(); last_cyc.delete(); abort_cyc.delete();
        done_cnt = 0;
        chk_cnt  = 0;
    endtask

    task automatic push_word(input int s, input logic [31:0] w);
        if (s == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic push_rand(input int s);
        for (int k = 0; k < WORDS; k++) push_word(s, $urandom);
    endtask

    task automatic drop_rest(input int s);
        for (int k = pos[s]; k < WORDS; k++) begin
            if (s == 0 && q0.size() > 0) void'(q0.pop_front());
            if (s == 1 && q1.size() > 0) void'(q1.pop_front());
        end
        pos[s] = 0;
    endtask

    // One clock cycle: drive sources, sample mid-cycle, score, advance the model
    task automatic step();
        bit          a0, a1, s;
        logic [31:0] w;
        req0_valid = en[0] && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 32'h0;
        req1_valid = en[1] && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 32'h0;
        @(negedge clock);
        n_checks++;
        if ({out_valid, out_first, out_last, msg_done, msg_abort, chk_err} !==
                {e_valid, e_first, e_last, e_done, e_abort, e_chk} ||
            out_data !== e_data || (e_valid && out_src !== e_src)) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got v%b f%b l%b d%b a%b c%b s%b %h required v%b f%b l%b d%b a%b c%b s%b %h",
                     cyc, out_valid, out_first, out_last, msg_done, msg_abort, chk_err, out_src, out_data,
                     e_valid, e_first, e_last, e_done, e_abort, e_chk, e_src, e_data);
        end
        n_checks++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            n_fail++;
            $display("FAIL ready_exclusive cyc=%0d got both ready required at most one", cyc);
        end
        if (out_valid && out_first) begin first_cyc.push_back(cyc); first_src.push_back(int'(out_src)); end
        if (out_valid && out_last) last_cyc.push_back(cyc);
        if (msg_abort) abort_cyc.push_back(cyc);
        if (msg_done) done_cnt++;
        if (chk_err) chk_cnt++;

        a0 = req0_valid && (req0_ready === 1'b1);
        a1 = req1_valid && (req1_ready === 1'b1);
        e_valid = a0 || a1;
        e_first = 1'b0; e_last = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_chk = 1'b0;
        if (e_valid) begin
            s = a1;
            w = s ? q1.pop_front() : q0.pop_front();
            e_data  = w;
            e_src   = s;
            e_first = (pos[s] == 0);
            e_last  = (pos[s] == WORDS - 1);
            e_done  = e_last;
            if (pos[s] == 0) msg_sum = 0;
            msg_sum += w[31:16] + w[15:0];
`ifdef ICMP_CHECKSUM_CHECK_EN
            if (e_last) e_chk = (fold16(msg_sum) != 16'hFFFF);
`endif
            pos[s] = e_last ? 0 : pos[s] + 1;
        end
        if ((req0_ready === 1'b1 && !req0_valid) || (req1_ready === 1'b1 && !req1_valid)) idle_run++;
        else idle_run = 0;
        if (idle_run == STALL_MAX) begin
            e_abort  = 1'b1;
            idle_run = 0;
            drop_rest((req1_ready === 1'b1) ? 1 : 0);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Assert reset asynchronously, check outputs at once, then release
    task automatic apply_reset();
        reset = 1'b1;
        en[0] = 1'b0; en[1] = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, out_valid, out_first, out_last, out_src, msg_done, msg_abort, chk_err} !== 9'b0 ||
            out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got r%b%b v%b f%b l%b s%b d%b a%b c%b %h required all zero",
                     req0_ready, req1_ready, out_valid, out_first, out_last, out_src, msg_done, msg_abort, chk_err, out_data);
        end
        for (int s = 0; s < 2; s++) if (pos[s] != 0) drop_rest(s);
        e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_chk = 1'b0;
        e_src = 1'b0; e_data = 32'h0; idle_run = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int target, input string name);
        for (int k = 0; k < 300 && done_cnt < target; k++) step();
        n_checks++;
        if (done_cnt != target) begin
            n_fail++;
            $display("FAIL %s_done_count got %0d required %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        clear_logs();
        repeat (3) step();
        n_checks++;
        if (first_src.size() != 0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle got %0d starts required 0", first_src.size());
        end
    endtask

    task automatic test_single();
        int t_en;
        clear_logs();
        push_word(0, 32'h0000_0032); push_word(0, 32'h0000_0000); push_word(0, 32'h00AB_AB32);
        push_word(0, 32'h00AB_AB32); push_word(0, 32'h00CA_A200);
        push_rand(0);
        en[0] = 1'b1;
        t_en = cyc;
        run_until_done(2, "single");
        n_checks++;
        if (first_cyc.size() < 1 || first_cyc[0] != t_en + 2 || first_src[0] != 0) begin
            n_fail++;
            $display("FAIL single_first_timing got cyc %0d required %0d", (first_cyc.size() > 0) ? first_cyc[0] : -1, t_en + 2);
        end
        n_checks++;
        if (last_cyc.size() < 1 || last_cyc[0] - first_cyc[0] != WORDS - 1) begin
            n_fail++;
            $display("FAIL single_burst_length got %0d required %0d", (last_cyc.size() > 0) ? last_cyc[0] - first_cyc[0] : -1, WORDS - 1);
        end
        en[0] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clear_logs();
        push_rand(0); push_rand(0); push_rand(1); push_rand(1);
        en[0] = 1'b1; en[1] = 1'b1;
        run_until_done(4, "b2b");
        n_checks++;
        if (first_src.size() != 4 || first_src[0] != 0 || first_src[1] != 1 || first_src[2] != 0 || first_src[3] != 1) begin
            n_fail++;
            $display("FAIL b2b_order got %0d starts required order 0,1,0,1", first_src.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (first_cyc.size() != 4 || last_cyc.size() != 4 || first_cyc[i+1] - last_cyc[i] != 2 ||
                last_cyc[i] - first_cyc[i] != WORDS - 1) begin
                n_fail++;
                $display("FAIL b2b_gap msg %0d got gap %0d required 2", i,
                         (first_cyc.size() == 4 && last_cyc.size() == 4) ? first_cyc[i+1] - last_cyc[i] : -1);
            end
        end
        en[0] = 1'b0; en[1] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_stall(input int gap);
        clear_logs();
        push_rand(0);
        en[0] = 1'b1;
        for (int k = 0; k < 20 && pos[0] != 3; k++) step();
        en[0] = 1'b0;
        repeat (gap) step();
        en[0] = 1'b1;
        run_until_done(1, "stall");
        n_checks++;
        if (abort_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL stall_no_abort gap %0d got %0d aborts required 0", gap, abort_cyc.size());
        end
        en[0] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_abort();
        int t0;
        clear_logs();
        push_rand(0);
        en[0] = 1'b1;
        for (int k = 0; k < 20 && pos[0] != 2; k++) step();
        en[0] = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 30 && abort_cyc.size() == 0; k++) step();
        n_checks++;
        if (abort_cyc.size() != 1 || abort_cyc[0] != t0 + STALL_MAX || done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_timing got %0d aborts at %0d done %0d required 1 at %0d done 0",
                     abort_cyc.size(), (abort_cyc.size() > 0) ? abort_cyc[0] : -1, done_cnt, t0 + STALL_MAX);
        end
        clear_logs();
        push_rand(0); push_rand(1);
        en[0] = 1'b1; en[1] = 1'b1;
        run_until_done(2, "abort_regrant");
        n_checks++;
        if (first_src.size() != 2 || first_src[0] != 1 || first_src[1] != 0) begin
            n_fail++;
            $display("FAIL abort_next_grant got %0d starts first src %0d required 1 then 0",
                     first_src.size(), (first_src.size() > 0) ? first_src[0] : -1);
        end
        en[0] = 1'b0; en[1] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        push_rand(0);
        en[0] = 1'b1;
        for (int k = 0; k < 20 && pos[0] != 3; k++) step();
        apply_reset();
        clear_logs();
        push_rand(0);
        en[0] = 1'b1;
        run_until_done(1, "reset_mid");
        n_checks++;
        if (first_src.size() != 1 || abort_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart got %0d starts %0d aborts required 1 and 0", first_src.size(), abort_cyc.size());
        end
        en[0] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_checksum();
        clear_logs();
        push_word(0, 32'h0800_F7FF);
        for (int k = 1; k < WORDS; k++) push_word(0, 32'h0);
        push_word(0, 32'h0800_0000);
        for (int k = 1; k < WORDS; k++) push_word(0, 32'h0);
        en[0] = 1'b1;
        run_until_done(2, "checksum");
        n_checks++;
`ifdef ICMP_CHECKSUM_CHECK_EN
        if (chk_cnt != 1) begin
`else
        if (chk_cnt != 0) begin
`endif
            n_fail++;
            $display("FAIL checksum_pulses got %0d", chk_cnt);
        end
        en[0] = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 400; c++) begin
            en[0] = ($urandom_range(0, 3) != 0);
            en[1] = ($urandom_range(0, 3) != 0);
            if (q0.size() < WORDS) push_rand(0);
            if (q1.size() < WORDS) push_rand(1);
            step();
        end
        en[0] = 1'b1; en[1] = 1'b1;
        for (int c = 0; c < 300 && (q0.size() + q1.size()) > 0; c++) step();
        n_checks++;
        if (q0.size() + q1.size() != 0 || done_cnt == 0) begin
            n_fail++;
            $display("FAIL random_drain got %0d words left %0d done required 0 left", q0.size() + q1.size(), done_cnt);
        end
        repeat (3) step();
    endtask

    initial begin
        en[0] = 1'b0; en[1] = 1'b0;
        pos[0] = 0; pos[1] = 0;
        idle_run = 0; msg_sum = 0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall(3);
        test_stall(STALL_MAX - 1);
        test_abort();
        test_reset_mid();
        test_checksum();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icmp_rx_arbiter.md
Name: icmp_rx_arbiter

Overview:
- Shares the single ICMP_read parser between two word-stream requesters; the parser takes one 32-bit word per clock.
- Grants whole messages round-robin and forwards each granted message word to the parser.
- Frames every message with first/last markers and aborts a message when its source stalls too long.
- Sits directly in front of ICMP_read in the receive path.

Parameters:
- WORDS, 5, words per ICMP message (header, unused, 3 payload words); legal range 2..16.
- STALL_MAX, 8, consecutive idle cycles of the granted source before the message is aborted; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  source 0 has a word on req0_data.
- req0_data  in  32  source 0 word.
- req0_ready  out  1  source 0 word is accepted this cycle.
- req1_valid  in  1  source 1 has a word on req1_data.
- req1_data  in  32  source 1 word.
- req1_ready  out  1  source 1 word is accepted this cycle.
- out_valid  out  1  out_data holds a word for the parser.
- out_data  out  32  word for the ICMP_read inputmessage port.
- out_first  out  1  out_data is word 0 of a message.
- out_last  out  1  out_data is word WORDS-1 of a message.
- out_src  out  1  source index of the message in flight.
- msg_done  out  1  one-cycle pulse, aligned with out_last.
- msg_abort  out  1  one-cycle pulse when a message is aborted.
- chk_err  out  1  checksum failure, aligned with msg_done (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs go to 0; out_data = 32'h0.
  - last_grant = 1, so source 0 wins the first tie.
  - Word counter, stall counter and checksum accumulator are cleared.
- Handshake: a word transfers on a clock edge where reqN_valid and reqN_ready are both 1.
  - reqN_ready is combinational: 1 only in XFER for the granted source.
  - reqN_ready does not depend on reqN_valid.
- Latency: a word accepted at edge t appears on out_data with out_valid=1 for exactly the cycle after t.
  - Whenever out_valid=0, out_data holds its previous value.
- States:
  - IDLE:
    - Both ready outputs are 0.
    - One valid source: grant it.
    - Both valid: grant the source != last_grant.
    - On a grant: update last_grant and out_src, clear the counters, go to XFER on the next edge.
    - Arbitration takes one cycle; no word is taken in IDLE.
  - XFER:
    - Each accepted word increments word_cnt and clears stall_cnt.
    - out_first=1 for word_cnt 0; out_last=1 for word_cnt WORDS-1.
    - A cycle with the granted valid=0 increments stall_cnt.
    - Accepting word WORDS-1 returns to IDLE on the same edge; msg_done pulses with that word on out_valid.
    - stall_cnt reaching STALL_MAX goes to ABORT.
  - ABORT:
    - One cycle; msg_abort=1, ready outputs 0, out_valid=0.
    - Next state is IDLE.
    - last_grant keeps the aborted source, so the other source wins the next tie.
- The non-granted source is never accepted, even if valid, until the grant ends.
- The granted source dropping valid mid-message is legal: word_cnt holds and out_valid is 0 that cycle.
- A reset mid-message discards the message; no msg_done or msg_abort pulse is produced.
- Back-to-back messages: at least one IDLE cycle separates them, so out_last and the next out_first are never adjacent.
- word_cnt is $clog2(WORDS) bits wide and never wraps within a message.
- stall_cnt is 8 bits wide and saturates at STALL_MAX.

Optional Feature:
- Macro: ICMP_CHECKSUM_CHECK_EN.
- Defined:
  - Each accepted word adds its upper and lower 16-bit halves into a 16-bit ones'-complement accumulator (end-around carry).
  - The accumulator is cleared at grant.
  - On the last word, chk_err=1 (with msg_done) if the final sum != 16'hFFFF.
  - chk_err is forced 0 on abort.
- Not defined: chk_err is tied 0 and no accumulator logic is built.

Test Plan:
- Reset released; req0_valid=1 with words 32'h0000_0032, 32'h0, 32'h00AB_AB32, 32'h00AB_AB32, 32'h00CA_A200 -> out_valid for 5 consecutive cycles, one cycle behind acceptance, with the same words in order; out_first on word 0; out_last and msg_done on word 4; out_src=0.
- Both sources valid continuously from reset -> messages alternate by source 0,1,0; each message 5 words; one IDLE cycle between messages; the idle source's ready stays 0.
- Source 0 drops valid for 3 cycles after word 2 (STALL_MAX=8) -> word_cnt holds; out_valid=0 for those 3 cycles; message completes normally with msg_done.
- Source 0 goes idle after word 1 -> msg_abort pulses once after 8 idle cycles; no msg_done; next grant goes to source 1 if both sources are valid.
- Reset asserted at word 3 -> all outputs 0 immediately; a later message starts with out_first and word_cnt 0.
- With ICMP_CHECKSUM_CHECK_EN:
  - Message 32'h0800_F7FF followed by four zero words -> chk_err=0.
  - Message 32'h0800_0000 followed by four zero words -> chk_err=1 with msg_done.
  - Without the macro, chk_err=0 for both messages.
